// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit driving the HI/LO register pair.
// Signed ops work on operand magnitudes and fix the signs when the result is written.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic                 neg_q, neg_d;       // negate product / quotient
  logic                 rneg_q, rneg_d;     // negate remainder (dividend sign)
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Datapath helpers: operand magnitudes and one shift-add / shift-subtract step.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
    addend    = acc_q[0] ? opnd_q : '0;
    msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = shifted - {1'b0, opnd_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
  end

  // Next-state logic: FSM sequencing, iteration step, result write and mthi/mtlo.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          // A zero divisor must leave the all-ones quotient unnegated.
          neg_d    = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]) & (|B);
          rneg_d   = signed_op & A[WIDTH-1];
          opnd_d   = op[1] ? b_mag : a_mag;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (diff[WIDTH]) acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else             acc_d = {diff[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Waits for done after the start edge; expects it after exp_cycles edges.
  task automatic wait_done(input string tag, input int unsigned exp_cycles);
    int unsigned k = 0;
    logic busy_late = 1'b0;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == exp_cycles - 1) busy_late = busy;
      if (done) begin
        k = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(k), 64'(exp_cycles));
    check({tag, " busy before result"}, 64'(busy_late), 64'd1);
    check({tag, " busy after result"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, " done falls"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    wait_done(tag, 33);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int unsigned ndone;
    int unsigned first_done;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*5",   2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult min*min",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu by 0",   2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div -7 by 0", 2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Restart attempt and mthi while busy must both be ignored.
    start = 1'b1; op = 2'b01; A = 32'd6; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_done = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      if (i == 10) begin start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd3; end
      if (i == 11) start = 1'b0;
      if (i == 12) begin mthi = 1'b1; wdata = 32'h0000_0055; end
      if (i == 13) mthi = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = i;
      end
    end
    check("repulse done count", 64'(ndone), 64'd1);
    check("repulse latency", 64'(first_done), 64'd33);
    check("repulse hi", 64'(hi), 64'd0);
    check("repulse lo", 64'(lo), 64'd42);

    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi lo kept", 64'(lo), 64'd42);

    mtlo = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h0BAD_F00D);
    check("mtlo hi kept", 64'(hi), 64'hDEAD_BEEF);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'hA5A5_5A5A);
    check("mthi+mtlo lo", 64'(lo), 64'hA5A5_5A5A);

    // start and mthi together: start wins, write dropped.
    start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9; mthi = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("collision hi kept", 64'(hi), 64'hA5A5_5A5A);
    check("collision busy", 64'(busy), 64'd1);
    wait_done("collision op", 33);
    check("collision op hi", 64'(hi), 64'd0);
    check("collision op lo", 64'(lo), 64'd81);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu 3*4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
